// File: rtl/snn_pkg.sv
// snn_pkg: shared constants, FSM encoding and saturating add for the SNN layer scheduler
package snn_pkg;
    localparam int S       = 25;
    localparam int N_MAX   = 16;
    localparam int AW      = 4;
    localparam int V_W     = 24;
    localparam int SUM_W   = 21;
    localparam int MAC_LAT = 2;
    localparam int RD_LAT  = 1;
    localparam int PIPE    = RD_LAT + MAC_LAT + 1;

    typedef enum logic [2:0] {IDLE, WAIT_IN, ISSUE, DRAIN, OUTPUT, DONE} state_t;

    function automatic logic [V_W-1:0] sat_add(input logic [V_W-1:0] a, input logic [SUM_W-1:0] b);
        logic [V_W:0] s;
        s = {1'b0, a} + {{(V_W + 1 - SUM_W){1'b0}}, b};
        return s[V_W] ? '1 : s[V_W-1:0];
    endfunction
endpackage

// File: rtl/snn_layer_sched_if.sv
// snn_layer_sched_if: config, spike, weight RAM, MAC and output handshake signals of the scheduler
interface snn_layer_sched_if;
    import snn_pkg::*;
    logic                 start;
    logic [AW:0]          num_neurons;
    logic [7:0]           num_steps;
    logic [V_W-1:0]       threshold;
    logic [3:0]           leak_shift;
    logic                 in_valid;
    logic                 in_ready;
    logic [S-1:0]         in_spikes;
    logic                 w_rd_en;
    logic [AW-1:0]        w_addr;
    logic [S*16-1:0]      w_data;
    logic [S-1:0]         mac_pixels;
    logic [S*16-1:0]      mac_weights;
    logic [SUM_W-1:0]     mac_sum;
    logic                 out_valid;
    logic                 out_ready;
    logic [N_MAX-1:0]     out_spikes;
    logic                 busy;
    logic                 done;

    modport slave (
        input  start, num_neurons, num_steps, threshold, leak_shift, in_valid, in_spikes, w_data, mac_sum, out_ready,
        output in_ready, w_rd_en, w_addr, mac_pixels, mac_weights, out_valid, out_spikes, busy, done
    );
    modport master (
        output start, num_neurons, num_steps, threshold, leak_shift, in_valid, in_spikes, w_data, mac_sum, out_ready,
        input  in_ready, w_rd_en, w_addr, mac_pixels, mac_weights, out_valid, out_spikes, busy, done
    );
endinterface

// File: rtl/snn_neuron_update.sv
// snn_neuron_update: leak, saturating accumulate and threshold/reset of one membrane potential
module snn_neuron_update
    import snn_pkg::*;
(
    input  logic [V_W-1:0]   v,
    input  logic [SUM_W-1:0] sum,
    input  logic [3:0]       leak_shift,
    input  logic [V_W-1:0]   threshold,
    output logic [V_W-1:0]   v_next,
    output logic             spike
);
    logic [V_W-1:0] leaked;
    logic [V_W-1:0] acc;

    // a shift of zero means no leak, not "subtract everything"
    always_comb begin
        leaked = v - ((leak_shift != 4'd0) ? (v >> leak_shift) : '0);
        acc    = sat_add(leaked, sum);
        spike  = acc >= threshold;
        v_next = spike ? '0 : acc;
    end
endmodule

// File: rtl/snn_layer_sched.sv
// snn_layer_sched: steps a spiking layer through timesteps, streaming weight rows into the MAC
module snn_layer_sched
    import snn_pkg::*;
(
    input logic               clk,
    input logic               rst,
    snn_layer_sched_if.slave  bus
);
    localparam logic [AW:0] NMAX_C = (AW + 1)'(N_MAX);

    state_t                     state, nxt;
    logic [AW:0]                n_cfg;
    logic [7:0]                 steps_cfg, step;
    logic [V_W-1:0]             thr;
    logic [3:0]                 ls;
    logic [AW-1:0]              idx;
    logic [PIPE-1:0]            vld;
    logic [PIPE-1:0][AW-1:0]    tag;
    logic [V_W-1:0]             mem [N_MAX];
    logic [N_MAX-1:0]           spikes;
    logic [S-1:0]               pix;
    logic [V_W-1:0]             v_next;
    logic                       fire;
    logic                       last_issue;
    logic                       out_fire;

    assign last_issue      = {1'b0, idx} == n_cfg - (AW + 1)'(1);
    assign out_fire        = state == OUTPUT && bus.out_ready;
    assign bus.in_ready    = state == WAIT_IN;
    assign bus.w_rd_en     = state == ISSUE;
    assign bus.w_addr      = state == ISSUE ? idx : '0;
    assign bus.mac_pixels  = pix;
    assign bus.mac_weights = bus.w_data;
    assign bus.out_valid   = state == OUTPUT;
    assign bus.out_spikes  = spikes;
    assign bus.busy        = state != IDLE;
    assign bus.done        = state == DONE;

    snn_neuron_update u_upd (
        .v          (mem[tag[PIPE-1]]),
        .sum        (bus.mac_sum),
        .leak_shift (ls),
        .threshold  (thr),
        .v_next     (v_next),
        .spike      (fire)
    );

    // state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : nxt;
    end

    // next-state: one timestep is accept input, issue rows, drain MAC, hand off spikes
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.start ? WAIT_IN : IDLE;
            WAIT_IN: nxt = bus.in_valid ? ISSUE : WAIT_IN;
            ISSUE:   nxt = last_issue ? DRAIN : ISSUE;
            DRAIN:   nxt = vld == '0 ? OUTPUT : DRAIN;
            OUTPUT:  nxt = !bus.out_ready ? OUTPUT : (step == steps_cfg - 8'd1 ? DONE : WAIT_IN);
            default: nxt = IDLE;
        endcase
    end

    // config latch, issue counter, return-tag pipeline and membrane updates
    always_ff @(posedge clk) begin
        if (rst) begin
            n_cfg     <= '0;
            steps_cfg <= '0;
            thr       <= '0;
            ls        <= '0;
            step      <= '0;
            idx       <= '0;
            vld       <= '0;
            tag       <= '0;
            pix       <= '0;
            spikes    <= '0;
            for (int i = 0; i < N_MAX; i++) mem[i] <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                n_cfg     <= (bus.num_neurons == '0 || bus.num_neurons > NMAX_C) ? NMAX_C : bus.num_neurons;
                steps_cfg <= bus.num_steps == 8'd0 ? 8'd1 : bus.num_steps;
                thr       <= bus.threshold;
                ls        <= bus.leak_shift;
                step      <= '0;
                for (int i = 0; i < N_MAX; i++) mem[i] <= '0;
            end
            if (state == WAIT_IN && bus.in_valid) begin
                pix    <= bus.in_spikes;
                spikes <= '0;
                idx    <= '0;
            end
            if (state == ISSUE) idx <= idx + AW'(1);
            vld <= {vld[PIPE-2:0], state == ISSUE};
            tag <= {tag[PIPE-2:0], idx};
            if (vld[PIPE-1]) begin
                mem[tag[PIPE-1]]    <= v_next;
                spikes[tag[PIPE-1]] <= fire;
            end
            if (out_fire) step <= step + 8'd1;
        end
    end
endmodule
